// File: rtl/mhp_tx_arbiter.sv
// Round-robin arbiter that serialises one MHP frame at a time onto the shared eth byte port.
// The header is latched at grant. The payload streams from the winner's FWFT FIFO, and the SCS is summed on the fly.
module mhp_tx_arbiter #(
  parameter int unsigned N_REQ = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [15:0]          i_src_addr,
  input  logic [N_REQ-1:0]     i_req,
  input  logic [16*N_REQ-1:0]  i_dst,
  input  logic [16*N_REQ-1:0]  i_size,
  input  logic [8*N_REQ-1:0]   i_dtype,
  input  logic [8*N_REQ-1:0]   i_pld_data,
  output logic [N_REQ-1:0]     o_pld_rd,
  output logic [N_REQ-1:0]     o_grant,
  output logic [7:0]           o_wdata,
  output logic                 o_wvalid,
  input  logic                 i_wready,
  output logic                 o_busy,
  output logic                 o_frame_done
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [3:0] {
    StIdle, StDst1, StDst2, StSrc1, StSrc2, StSize1, StSize2, StDtype, StPld, StScs1, StScs2,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] gnt_idx_q, gnt_idx_d;
  logic [IdxW-1:0] rr_q, rr_d;
  logic [15:0]     dst_q, dst_d;
  logic [15:0]     size_q, size_d;
  logic [7:0]      dtype_q, dtype_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [15:0]     csum_q, csum_d;

  logic [IdxW-1:0]  win_idx, cand_idx;
  logic             win_found;
  int unsigned      cand;
  logic [N_REQ-1:0] gnt_oh;
  logic             in_frame;
  logic             xfer;
  logic             summed;

  // Search upward from the round-robin pointer, wrapping at N_REQ.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = 32'(rr_q) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_idx = IdxW'(cand);
      if (!win_found && i_req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  assign gnt_oh   = N_REQ'(1) << gnt_idx_q;
  assign in_frame = (state_q != StIdle) && (state_q != StDone);
  assign xfer     = o_wvalid && i_wready;
  assign summed   = in_frame && (state_q != StScs1) && (state_q != StScs2);

  always_comb begin
    o_wdata  = 8'h00;
    o_wvalid = 1'b1;
    case (state_q)
      StDst1:  o_wdata = dst_q[15:8];
      StDst2:  o_wdata = dst_q[7:0];
      StSrc1:  o_wdata = i_src_addr[15:8];
      StSrc2:  o_wdata = i_src_addr[7:0];
      StSize1: o_wdata = size_q[15:8];
      StSize2: o_wdata = size_q[7:0];
      StDtype: o_wdata = dtype_q;
      StPld:   o_wdata = i_pld_data[32'(gnt_idx_q)*8 +: 8];
      StScs1:  o_wdata = csum_q[15:8];
      StScs2:  o_wdata = csum_q[7:0];
      default: o_wvalid = 1'b0;
    endcase
  end

  assign o_grant      = in_frame ? gnt_oh : '0;
  assign o_busy       = in_frame;
  assign o_pld_rd     = ((state_q == StPld) && i_wready) ? gnt_oh : '0;
  assign o_frame_done = (state_q == StDone);

  always_comb begin
    state_d   = state_q;
    gnt_idx_d = gnt_idx_q;
    rr_d      = rr_q;
    dst_d     = dst_q;
    size_d    = size_q;
    dtype_d   = dtype_q;
    cnt_d     = cnt_q;
    csum_d    = csum_q;
    if (xfer && summed) csum_d = csum_q + {8'h00, o_wdata};
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          gnt_idx_d = win_idx;
          dst_d     = i_dst[32'(win_idx)*16 +: 16];
          size_d    = i_size[32'(win_idx)*16 +: 16];
          dtype_d   = i_dtype[32'(win_idx)*8 +: 8];
          csum_d    = 16'h0000;
          state_d   = StDst1;
        end
      end
      StDst1:  if (xfer) state_d = StDst2;
      StDst2:  if (xfer) state_d = StSrc1;
      StSrc1:  if (xfer) state_d = StSrc2;
      StSrc2:  if (xfer) state_d = StSize1;
      StSize1: if (xfer) state_d = StSize2;
      StSize2: if (xfer) state_d = StDtype;
      StDtype: begin
        if (xfer) begin
          cnt_d   = 16'h0000;
          state_d = (size_q == 16'h0000) ? StScs1 : StPld;
        end
      end
      StPld: begin
        if (xfer) begin
          if (cnt_q == size_q - 16'd1) state_d = StScs1;
          else                         cnt_d   = cnt_q + 16'd1;
        end
      end
      StScs1: if (xfer) state_d = StScs2;
      StScs2: if (xfer) state_d = StDone;
      StDone: begin
        rr_d    = (gnt_idx_q == IdxW'(N_REQ - 1)) ? '0 : gnt_idx_q + IdxW'(1);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      gnt_idx_q <= '0;
      rr_q      <= '0;
      dst_q     <= 16'h0000;
      size_q    <= 16'h0000;
      dtype_q   <= 8'h00;
      cnt_q     <= 16'h0000;
      csum_q    <= 16'h0000;
    end else begin
      state_q   <= state_d;
      gnt_idx_q <= gnt_idx_d;
      rr_q      <= rr_d;
      dst_q     <= dst_d;
      size_q    <= size_d;
      dtype_q   <= dtype_d;
      cnt_q     <= cnt_d;
      csum_q    <= csum_d;
    end
  end

endmodule

// File: tb/tb_mhp_tx_arbiter.sv
// Bench for mhp_tx_arbiter. Frames observed on the eth port are compared against frames
// rebuilt from the source fields, with the FIFO contents mirrored in queues.
module tb_mhp_tx_arbiter;

  localparam int NReq = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [15:0]        src_addr;
  logic [NReq-1:0]    req;
  logic [16*NReq-1:0] dst, size;
  logic [8*NReq-1:0]  dtype, pld_data;
  logic [NReq-1:0]    pld_rd, grant;
  logic [7:0]         wdata;
  logic               wvalid, wready, busy, frame_done;

  always #5 clk = ~clk;

  mhp_tx_arbiter #(.N_REQ(NReq)) dut (
    .i_clk(clk), .i_rst(rst), .i_src_addr(src_addr), .i_req(req), .i_dst(dst),
    .i_size(size), .i_dtype(dtype), .i_pld_data(pld_data), .o_pld_rd(pld_rd),
    .o_grant(grant), .o_wdata(wdata), .o_wvalid(wvalid), .i_wready(wready), .o_busy(busy),
    .o_frame_done(frame_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] fifo0[$], fifo1[$], exp0[$], exp1[$], obs[$], exp_frame[$];
  logic [7:0] junk, stall_byte;
  logic [NReq-1:0] obs_grant;
  int   rr_model, ready_mode, pops;
  logic stall_prev, done_prev, done_seen, grant_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic refresh();
    pld_data[7:0]  = (fifo0.size() > 0) ? fifo0[0] : 8'h00;
    pld_data[15:8] = (fifo1.size() > 0) ? fifo1[0] : 8'h00;
    case (ready_mode)
      0:       wready = 1'b1;
      1:       wready = ~wready;
      default: wready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic step();
    logic [NReq-1:0] rd;
    @(negedge clk);
    if (done_prev) check("done_pulse_width", frame_done, 0);
    done_prev = frame_done;
    if (stall_prev) begin
      check("stall_valid", wvalid, 1);
      check("stall_data", wdata, stall_byte);
    end
    stall_prev = wvalid && !wready;
    stall_byte = wdata;
    if (wvalid && wready) begin
      if (!grant_seen) begin
        obs_grant  = grant;
        grant_seen = 1'b1;
      end
      obs.push_back(wdata);
    end
    rd = pld_rd;
    if (rd != '0) check("pld_rd_on_accept", (wvalid && wready && ((rd & ~grant) == '0)), 1);
    if (frame_done) begin
      done_seen = 1'b1;
      check("done_idle_outputs", {busy, wvalid, |grant}, 0);
    end
    @(posedge clk);
    #1;
    if (rd[0]) begin
      if (fifo0.size() > 0) junk = fifo0.pop_front();
      pops++;
    end
    if (rd[1]) begin
      if (fifo1.size() > 0) junk = fifo1.pop_front();
      pops++;
    end
    refresh();
  endtask

  function automatic int pick_winner();
    for (int i = 0; i < NReq; i++) begin
      int s = (rr_model + i) % NReq;
      if (req[s]) return s;
    end
    return -1;
  endfunction

  task automatic set_fields(input int s, input logic [15:0] d, input logic [15:0] z,
                            input logic [7:0] dt);
    dst[s*16 +: 16]  = d;
    size[s*16 +: 16] = z;
    dtype[s*8 +: 8]  = dt;
  endtask

  task automatic fill(input int s, input int n, input bit all_ff);
    logic [7:0] b;
    for (int k = 0; k < n; k++) begin
      b = all_ff ? 8'hFF : 8'($urandom);
      if (s == 0) begin fifo0.push_back(b); exp0.push_back(b); end
      else        begin fifo1.push_back(b); exp1.push_back(b); end
    end
    refresh();
  endtask

  // Reference frame: header fields, payload in FIFO order, then the 16-bit sum of everything before.
  task automatic build_expected(input int w);
    logic [15:0] d, z, sum;
    logic [7:0]  dt, b;
    d  = dst[w*16 +: 16];
    z  = size[w*16 +: 16];
    dt = dtype[w*8 +: 8];
    exp_frame = {};
    exp_frame.push_back(d[15:8]);        exp_frame.push_back(d[7:0]);
    exp_frame.push_back(src_addr[15:8]); exp_frame.push_back(src_addr[7:0]);
    exp_frame.push_back(z[15:8]);        exp_frame.push_back(z[7:0]);
    exp_frame.push_back(dt);
    for (int k = 0; k < int'(z); k++) begin
      b = (w == 0) ? exp0.pop_front() : exp1.pop_front();
      exp_frame.push_back(b);
    end
    sum = 16'h0000;
    foreach (exp_frame[k]) sum = sum + 16'(exp_frame[k]);
    exp_frame.push_back(sum[15:8]);
    exp_frame.push_back(sum[7:0]);
  endtask

  task automatic run_frame(input string tag, input bit scramble);
    int w;
    int sz;
    w = pick_winner();
    sz = int'(size[w*16 +: 16]);
    build_expected(w);
    obs = {};
    pops = 0;
    done_seen = 1'b0;
    grant_seen = 1'b0;
    for (int c = 0; c < 4000 && !done_seen; c++) begin
      step();
      if (scramble && c == 3) begin
        dst   = 32'($urandom);
        size  = 32'($urandom);
        dtype = 16'($urandom);
        req   = '0;
      end
    end
    check({tag, "_done"}, done_seen, 1);
    check({tag, "_len"}, obs.size(), exp_frame.size());
    if (obs.size() == exp_frame.size())
      foreach (exp_frame[k]) check({tag, "_byte"}, obs[k], exp_frame[k]);
    check({tag, "_grant"}, obs_grant, 1 << w);
    check({tag, "_pops"}, pops, sz);
    rr_model = (w + 1) % NReq;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    fifo0 = {}; fifo1 = {}; exp0 = {}; exp1 = {};
    rr_model = 0;
    stall_prev = 1'b0;
    done_prev = 1'b0;
    refresh();
  endtask

  initial begin
    rst = 1'b1; req = '0; dst = '0; size = '0; dtype = '0; pld_data = '0;
    src_addr = 16'h0001; wready = 1'b1; ready_mode = 0;
    stall_prev = 1'b0; done_prev = 1'b0; rr_model = 0; pops = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wvalid", wvalid, 0);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_pld_rd", pld_rd, 0);
    check("rst_done", frame_done, 0);
    check("rst_wdata", wdata, 0);
    rst = 1'b0;
    step(); step();
    check("idle_no_req", {busy, wvalid}, 0);

    // Worked example from the frame format description.
    set_fields(0, 16'hFFFF, 16'd2, 8'h83);
    fifo0.push_back(8'hAA); exp0.push_back(8'hAA);
    fifo0.push_back(8'h55); exp0.push_back(8'h55);
    req = 2'b01;
    refresh();
    run_frame("basic", 1'b0);
    req = '0;
    if (obs.size() == 11) check("basic_scs", {obs[9], obs[10]}, 16'h0383);

    // Both requesting from reset: alternates 0, 1, 0.
    do_reset();
    set_fields(0, 16'h1234, 16'd3, 8'h05);
    set_fields(1, 16'hBEEF, 16'd4, 8'h8A);
    fill(0, 6, 1'b0);
    fill(1, 4, 1'b0);
    req = 2'b11;
    run_frame("alt0", 1'b0);
    run_frame("alt1", 1'b0);
    run_frame("alt2", 1'b0);
    req = '0;

    ready_mode = 1;
    set_fields(1, 16'h0A0B, 16'd5, 8'h11);
    fill(1, 5, 1'b0);
    req = 2'b10;
    run_frame("toggle", 1'b0);
    req = '0;
    ready_mode = 0;

    set_fields(0, 16'h4321, 16'd0, 8'h7F);
    req = 2'b01;
    refresh();
    run_frame("size0", 1'b0);
    req = '0;
    check("size0_nbytes", obs.size(), 9);

    set_fields(1, 16'hFFFF, 16'd300, 8'hFF);
    fill(1, 300, 1'b1);
    req = 2'b10;
    run_frame("wrap", 1'b0);
    req = '0;

    for (int it = 0; it < 30; it++) begin
      int w;
      ready_mode = $urandom_range(0, 2);
      req = 2'($urandom_range(1, 3));
      set_fields(0, 16'($urandom), 16'($urandom_range(0, 12)), 8'($urandom));
      set_fields(1, 16'($urandom), 16'($urandom_range(0, 12)), 8'($urandom));
      src_addr = 16'($urandom);
      w = pick_winner();
      fill(w, int'(size[w*16 +: 16]), 1'b0);
      run_frame("rand", 1'b1);
      req = '0;
    end
    ready_mode = 0;
    refresh();

    // Reset in the middle of a payload.
    set_fields(1, 16'h5555, 16'd10, 8'h22);
    fill(1, 10, 1'b0);
    req = 2'b10;
    pops = 0;
    for (int c = 0; c < 60 && pops < 3; c++) step();
    check("rst_reach_pld", pops >= 3, 1);
    rst = 1'b1;
    req = '0;
    @(posedge clk);
    #1;
    check("midrst_wvalid", wvalid, 0);
    check("midrst_grant", grant, 0);
    check("midrst_busy", busy, 0);
    check("midrst_pld_rd", pld_rd, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    fifo0 = {}; fifo1 = {}; exp0 = {}; exp1 = {};
    rr_model = 0; stall_prev = 1'b0; done_prev = 1'b0;
    pops = 0;
    refresh();
    repeat (3) step();
    check("post_rst_no_pop", pops, 0);
    set_fields(0, 16'h0042, 16'd4, 8'h90);
    set_fields(1, 16'h0099, 16'd2, 8'h91);
    fill(0, 4, 1'b0);
    req = 2'b11;
    run_frame("post_rst", 1'b0);
    req = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
